// File: rtl/minterm_pkg.sv
// rtl/minterm_pkg.sv - shared types, default parameters and derived widths for minterm_capture
//
// Contents:
//   state_t             sweep FSM state (IDLE, SWEEP)
//   DEFAULT_N_VARS      default number of function inputs
//   DEFAULT_SETTLE      default extra hold cycles per vector
//   DEFAULT_N_MINTERMS  default minterm mask width (2**N_VARS)
//   DEFAULT_COUNT_W     default true-minterm count width (N_VARS+1)
//   settle_cnt_w()      width of the per-vector settle counter
package minterm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int DEFAULT_N_VARS     = 4;
    localparam int DEFAULT_SETTLE     = 1;
    localparam int DEFAULT_N_MINTERMS = 2 ** DEFAULT_N_VARS;
    localparam int DEFAULT_COUNT_W    = DEFAULT_N_VARS + 1;

    // A zero settle time still needs a one-bit counter so the vector
    // declarations stay legal; the counter then simply never leaves 0.
    function automatic int settle_cnt_w(input int settle);
        return (settle > 0) ? $clog2(settle + 1) : 1;
    endfunction

endpackage

// File: rtl/minterm_seq.sv
// rtl/minterm_seq.sv - input vector counter plus per-vector settle counter
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   clear   in   restart the sweep at vector 0 (start accepted)
//   run     in   sweep in progress; counters advance only while high
//   vec     out  N_VARS  vector currently driven to the function under test
//   sample  out  1       high during the last hold cycle of the current vector
//   last    out  1       sample on the final vector (2**N_VARS-1)
module minterm_seq
    import minterm_pkg::*;
#(
    parameter int N_VARS = DEFAULT_N_VARS,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              run,
    output logic [N_VARS-1:0] vec,
    output logic              sample,
    output logic              last
);

    localparam int                SW         = settle_cnt_w(SETTLE);
    localparam logic [SW-1:0]     SETTLE_MAX = SW'(SETTLE);
    localparam logic [N_VARS-1:0] VEC_MAX    = '1;

    logic [SW-1:0] settle_cnt;

    // The strobe is combinational so the top captures s_in on the very edge
    // that ends the hold window, while vec still addresses the sampled bit.
    assign sample = run && (settle_cnt == SETTLE_MAX);
    assign last   = sample && (vec == VEC_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (clear) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (sample) begin
            settle_cnt <= '0;
            vec        <= last ? '0 : vec + 1'b1;
        end else if (run) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/minterm_capture.sv
// rtl/minterm_capture.sv - sequential truth-table reader for a combinational function under test
//
// Optional feature macro: EXPECT_CMP_EN (adds expected/match/first_bad comparator)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   sweep request, ignored while busy
//   s_in       in   output of the function under test
//   vec        out  N_VARS      input vector driven to the function under test
//   busy       out  1           sweep in progress
//   done       out  1           one-cycle pulse, results valid
//   minterms   out  2**N_VARS   bit k = f(k)
//   count      out  N_VARS+1    number of set bits in minterms
//   expected   in   2**N_VARS   reference mask            (EXPECT_CMP_EN only)
//   match      out  1           minterms == expected      (EXPECT_CMP_EN only)
//   first_bad  out  N_VARS      lowest mismatching index  (EXPECT_CMP_EN only)
module minterm_capture
    import minterm_pkg::*;
#(
    parameter int N_VARS = DEFAULT_N_VARS,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   s_in,
    output logic [N_VARS-1:0]      vec,
    output logic                   busy,
    output logic                   done,
    output logic [2**N_VARS-1:0]   minterms,
    output logic [N_VARS:0]        count
`ifdef EXPECT_CMP_EN
    ,
    input  logic [2**N_VARS-1:0]   expected,
    output logic                   match,
    output logic [N_VARS-1:0]      first_bad
`endif
);

    localparam int N_MINTERMS = 2 ** N_VARS;

    state_t                  state;
    logic                    seq_clear;
    logic                    seq_run;
    logic                    sample;
    logic                    last;
    logic [N_MINTERMS-1:0]   minterms_next;

    assign seq_clear = (state == IDLE) && start;
    assign seq_run   = (state == SWEEP);

    minterm_seq #(
        .N_VARS (N_VARS),
        .SETTLE (SETTLE)
    ) u_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (seq_clear),
        .run    (seq_run),
        .vec    (vec),
        .sample (sample),
        .last   (last)
    );

    // Mask including the bit being sampled this cycle; the comparator needs
    // the complete mask on the final edge, before the register has it.
    always_comb begin
        minterms_next = minterms;
        if (sample) begin
            minterms_next[vec] = s_in;
        end
    end

`ifdef EXPECT_CMP_EN
    logic [N_MINTERMS-1:0] diff;
    logic [N_VARS-1:0]     bad_idx;

    // Scan from the top down so the lowest mismatching index wins.
    always_comb begin
        diff    = minterms_next ^ expected;
        bad_idx = '0;
        for (int k = N_MINTERMS - 1; k >= 0; k--) begin
            if (diff[k]) begin
                bad_idx = N_VARS'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            minterms  <= '0;
            count     <= '0;
`ifdef EXPECT_CMP_EN
            match     <= 1'b0;
            first_bad <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SWEEP;
                        busy     <= 1'b1;
                        minterms <= '0;
                        count    <= '0;
`ifdef EXPECT_CMP_EN
                        match     <= 1'b0;
                        first_bad <= '0;
`endif
                    end
                end
                SWEEP: begin
                    if (sample) begin
                        minterms <= minterms_next;
                        count    <= count + {{N_VARS{1'b0}}, s_in};
                    end
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef EXPECT_CMP_EN
                        match     <= ~|diff;
                        first_bad <= bad_idx;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_capture.sv
// tb/tb_minterm_capture.sv - self-checking bench for minterm_capture
module tb_minterm_capture;

    localparam int SETTLE_A = 1;
    localparam int SETTLE_B = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        s_in_a;
    logic        s_in_b;
    logic [3:0]  vec_a, vec_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] minterms_a, minterms_b;
    logic [4:0]  count_a, count_b;
    logic [15:0] tt_a = 16'h0000;
    logic [15:0] exp_a = 16'h0000;
    logic [15:0] exp_b = 16'hAAAA;
`ifdef EXPECT_CMP_EN
    logic        match_a, match_b;
    logic [3:0]  fb_a, fb_b;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb s_in_a = tt_a[vec_a];
    always_comb s_in_b = vec_b[0];

    minterm_capture #(.N_VARS(4), .SETTLE(SETTLE_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .s_in(s_in_a),
        .vec(vec_a), .busy(busy_a), .done(done_a),
        .minterms(minterms_a), .count(count_a)
`ifdef EXPECT_CMP_EN
        , .expected(exp_a), .match(match_a), .first_bad(fb_a)
`endif
    );

    minterm_capture #(.N_VARS(4), .SETTLE(SETTLE_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .s_in(s_in_b),
        .vec(vec_b), .busy(busy_b), .done(done_b),
        .minterms(minterms_b), .count(count_b)
`ifdef EXPECT_CMP_EN
        , .expected(exp_b), .match(match_b), .first_bad(fb_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference truth table of x,y,w,z = vec[3],vec[2],vec[1],vec[0]:
    // ~x&y&~w | x&y&z | ~y&w
    function automatic logic [15:0] ref_func_tt();
        logic [15:0] t;
        logic [3:0]  k;
        logic        x, y, w, z;
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            x = k[3]; y = k[2]; w = k[1]; z = k[0];
            t[i] = (~x & y & ~w) | (x & y & z) | (~y & w);
        end
        return t;
    endfunction

    function automatic logic [3:0] lowest_diff(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 16; i++)
            if (a[i] != b[i]) return 4'(i);
        return 4'd0;
    endfunction

    // Called at the first falling edge after the accepting edge; returns at
    // the falling edge where done is high (or after the cycle budget).
    task automatic wait_done_a(input string tag);
        int m = 0;
        int trace_err = 0;
        while (done_a !== 1'b1 && m < 100) begin
            if (busy_a !== 1'b1 || vec_a !== 4'(m / (SETTLE_A + 1))) trace_err++;
            @(negedge clk);
            m++;
        end
        check({tag, "_trace"}, trace_err, 0);
        check({tag, "_latency"}, m, 16 * (SETTLE_A + 1));
    endtask

    task automatic sweep_a(input logic [15:0] t, input logic [15:0] exp_mask,
                           input logic [15:0] cmp_mask, input string tag);
        tt_a  = t;
        exp_a = cmp_mask;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(tag);
        check({tag, "_minterms"}, minterms_a, exp_mask);
        check({tag, "_count"}, count_a, 32'($countones(exp_mask)));
        check({tag, "_busy_end"}, busy_a, 0);
        check({tag, "_vec_end"}, vec_a, 0);
`ifdef EXPECT_CMP_EN
        check({tag, "_match"}, match_a, (cmp_mask == exp_mask) ? 1 : 0);
        check({tag, "_first_bad"}, fb_a, lowest_diff(exp_mask, cmp_mask));
`endif
        @(negedge clk);
        check({tag, "_done_pulse"}, done_a, 0);
        check({tag, "_hold"}, minterms_a, exp_mask);
    endtask

    initial begin
        logic [15:0] f_tt;
        logic [15:0] r;
        int seen;
        int m;
        int trace_err;

        f_tt = ref_func_tt();

        // reset state
        @(negedge clk);
        check("rst_vec", vec_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_minterms", minterms_a, 0);
        check("rst_count", count_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed functions
        sweep_a(f_tt, 16'hAC3C, 16'hAC3C, "func");
        sweep_a(16'h0000, 16'h0000, 16'h0000, "zero");
        sweep_a(16'hFFFF, 16'hFFFF, 16'hFFFF, "ones");
        check("ones_count_full", count_a, 5'b10000);

        // comparator cases (plain sweeps when the comparator is absent)
        sweep_a(f_tt, 16'hAC3C, 16'hAC3D, "cmp_bad");
        sweep_a(f_tt, 16'hAC3C, 16'hAC3C, "cmp_good");

        // random functions
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom);
            sweep_a(r, r, 16'($urandom), $sformatf("rand%0d", i));
        end

        // SETTLE=0 instance, s_in=vec[0], stray start mid-sweep
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        m = 0;
        trace_err = 0;
        while (done_b !== 1'b1 && m < 100) begin
            if (busy_b !== 1'b1 || vec_b !== 4'(m)) trace_err++;
            @(negedge clk);
            m++;
            start_b = (m == 5);
        end
        start_b = 1'b0;
        check("s0_trace", trace_err, 0);
        check("s0_latency", m, 16);
        check("s0_minterms", minterms_b, 16'hAAAA);
        check("s0_count", count_b, 8);
`ifdef EXPECT_CMP_EN
        check("s0_match", match_b, 1);
`endif
        @(negedge clk);
        check("s0_idle_after", busy_b, 0);

        // asynchronous reset mid-sweep
        tt_a = 16'hFFFF;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_vec", vec_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        check("arst_minterms", minterms_a, 0);
        check("arst_count", count_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) seen++;
        end
        check("arst_no_done", seen, 0);
        sweep_a(f_tt, 16'hAC3C, 16'hAC3C, "after_rst");

        // back-to-back: start held high through done
        tt_a = 16'hFFFF;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        wait_done_a("b2b1");
        check("b2b1_minterms", minterms_a, 16'hFFFF);
        check("b2b1_count", count_a, 16);
        @(negedge clk);
        start_a = 1'b0;
        check("b2b2_busy", busy_a, 1);
        check("b2b2_done", done_a, 0);
        check("b2b2_cleared", minterms_a, 0);
        check("b2b2_count_cleared", count_a, 0);
        tt_a = f_tt;
        wait_done_a("b2b2");
        check("b2b2_minterms", minterms_a, 16'hAC3C);
        check("b2b2_count", count_a, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
